systolic_array_os: RTL
======================

// Module: systolic_array_os
// PURPOSE
//  Parametrised output-stationary systolic matrix-multiply engine: computes C[ROWS][COLS] = A[ROWS][K] x B[K][COLS].
//  Includes on-chip input skew, a start/valid/ready load protocol, a fixed flush phase and a row-serial readout FSM.
//  Sits between the MM operand fetch unit (streams one A column and one B row per beat) and the result writeback buffer.
// PARAMETERS
//  ROWS  4   PE rows; number of A elements per beat
//  COLS  4   PE columns; number of B elements per beat
//  DW    8   signed operand width
//  AW    24  signed accumulator / result width (AW >= 2*DW)
//  KW    8   width of k_len; maximum K = 2**KW-1
// PORTS
//  clk          in   1          clock, rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  start        in   1          begin job; sampled only in IDLE
//  k_len        in   KW         number of input beats for this job; sampled with start
//  busy         out  1          high from the cycle after start acceptance until the cycle after done
//  in_valid     in   1          a_data/b_data beat valid
//  in_ready     out  1          high only in LOAD
//  a_data       in   ROWS*DW    A column k; element i at [i*DW +: DW]
//  b_data       in   COLS*DW    B row k; element j at [j*DW +: DW]
//  out_valid    out  1          result row valid
//  out_ready    in   1          downstream accepts row
//  out_row      out  $clog2(ROWS) index of presented row
//  out_data     out  COLS*AW    C[out_row][j] at [j*AW +: AW]
//  done         out  1          one-cycle pulse on final row handshake
// BEHAVIOUR
//  Reset: FSM=IDLE; busy, in_ready, out_valid, done = 0; out_row = 0; out_data = 0; all skew, shift and accumulator registers = 0 with valid tags cleared.
//  FSM: IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
//   IDLE : start=1 -> clear all accumulators, latch k_len, beat_cnt=0. Next state is LOAD, or FLUSH if k_len==0.
//   LOAD : in_ready=1. Beat accepted on in_valid&in_ready and beat_cnt increments. After beat k_len-1 is accepted -> FLUSH.
//          When in_valid=0, a bubble (zero data, valid tag=0) is injected; the array keeps shifting every cycle.
//   FLUSH: in_ready=0; bubbles are injected; fixed ROWS+COLS-1 cycles -> DRAIN.
//   DRAIN: out_valid=1; out_row counts 0..ROWS-1; a row advances only on out_valid&out_ready. out_data is stable while stalled.
//          On the handshake of row ROWS-1: done=1 for that cycle -> IDLE. busy drops the following cycle.
//  Skew: A element i is delayed i cycles and B element j is delayed j cycles before entering the edge of the array.
//   Each operand carries a valid tag. A operands shift right, B operands shift down, one PE per cycle.
//  PE(i,j): when both operand tags are valid, acc += sext(a*b), computed as a signed DW x DW product sign-extended to AW.
//   Otherwise acc holds its value.
//  Latency: with back-to-back beats, the first out_valid occurs k_len+ROWS+COLS cycles after start acceptance.
//  Boundaries:
//   - start while busy: ignored.
//   - k_len==0: produces an all-zero result and is still drained.
//   - in_valid during IDLE, FLUSH or DRAIN: ignored.
//   - out_ready held low: indefinite stall in DRAIN; no data is lost.
//   - rst_n asserted mid-job: immediate return to the reset state; the partial result is discarded.
// CONFIGURATION
//  SYSTOLIC_SAT_EN defined: accumulation saturates to [-2**(AW-1), 2**(AW-1)-1] and a sticky per-job output sat_flag is added.
//   sat_flag is cleared on start, set if any PE clamped, and valid while in DRAIN.
//  SYSTOLIC_SAT_EN undefined: accumulation wraps modulo 2**AW and the sat_flag port is absent.
// STRUCTURE
//  Shared package: the operand-with-valid-tag struct (data + valid), the FSM state enum, and the AW/DW sign-extension helper function.
//  Sub-module systolic_pe: one instance per grid position. Contains operand/tag pass-through registers, the MAC, the clear input and the optional saturation logic.
//  Top level holds the skew chains, the FSM and counters, and the readout mux.
// TESTING
//  1. ROWS=COLS=4, K=4, A=I (identity), B[k][j]=k*4+j, continuous beats -> rows read back equal B; first out_valid at cycle 12 after start.
//  2. K=3, all operands -128 -> every C element = 3*16384 = 49152; a negative path with A=-1, B=5 gives C=-15.
//  3. K=8, in_valid toggled 1/0 each cycle -> result identical to the continuous-beat case; in_ready=0 in FLUSH and DRAIN.
//  4. out_ready=0 for 10 cycles at row 1 -> out_row=1 and out_data held; done pulses exactly once after row 3 is accepted.
//  5. start asserted while busy, and k_len=0 -> start ignored; zero job drains 4 all-zero rows with done pulse.
//  6. rst_n low during LOAD beat 2, then a new job -> no residue from the aborted job;
//     with SYSTOLIC_SAT_EN, AW=16 and K=4 of 127*127 -> C=32767 and sat_flag=1.

Source files
------------

// File: rtl/systolic_array_os_pkg.sv
// Shared types for the output-stationary systolic array: the operand-with-tag struct,
// the control FSM state enum and the product sign-extension helper.
package systolic_array_os_pkg;

  localparam int SA_DW    = 8;
  localparam int SA_EXT_W = 64;

  typedef struct packed {
    logic                    valid;
    logic signed [SA_DW-1:0] data;
  } operand_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

  // Full-precision signed product, sign-extended so callers can truncate to any AW >= 2*DW.
  function automatic logic signed [SA_EXT_W-1:0] sext_prod(input logic signed [SA_DW-1:0] a,
                                                           input logic signed [SA_DW-1:0] b);
    logic signed [2*SA_DW-1:0] p;
    p = a * b;
    return SA_EXT_W'(p);
  endfunction

endpackage

// File: rtl/systolic_array_os_pe.sv
// One processing element: forwards A right and B down one cycle later and accumulates a*b.
// SYSTOLIC_SAT_EN selects saturating accumulation with a sticky clamp flag.
module systolic_pe
  import systolic_array_os_pkg::*;
#(
  parameter int AW = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  operand_t             i_a,
  input  operand_t             i_b,
  output operand_t             o_a,
  output operand_t             o_b,
  output logic signed [AW-1:0] o_acc
`ifdef SYSTOLIC_SAT_EN
  ,
  output logic                 o_sat
`endif
);

  operand_t             r_a;
  operand_t             r_b;
  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_prod;
  logic signed [AW-1:0] w_acc_next;
  logic                 w_fire;

  assign w_fire = i_a.valid & i_b.valid;
  assign w_prod = AW'(sext_prod(i_a.data, i_b.data));

`ifdef SYSTOLIC_SAT_EN
  logic signed [AW:0] w_sum;
  logic               w_ovf;
  logic               r_sat;

  // One guard bit is enough to detect overflow of a two-operand add.
  assign w_sum = {r_acc[AW-1], r_acc} + {w_prod[AW-1], w_prod};
  assign w_ovf = w_sum[AW] ^ w_sum[AW-1];

  always_comb begin
    w_acc_next = w_sum[AW-1:0];
    if (w_ovf) begin
      w_acc_next = w_sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (i_clr) begin
      r_sat <= 1'b0;
    end else if (w_fire && w_ovf) begin
      r_sat <= 1'b1;
    end
  end

  assign o_sat = r_sat;
`else
  assign w_acc_next = r_acc + w_prod;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else begin
      r_a <= i_a;
      r_b <= i_b;
      if (i_clr) begin
        r_acc <= '0;
      end else if (w_fire) begin
        r_acc <= w_acc_next;
      end
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule

// File: rtl/systolic_array_os.sv
// Output-stationary systolic matrix multiply C = A x B with input skew, load/flush/drain FSM
// and row-serial readout. SYSTOLIC_SAT_EN adds saturating accumulation and the sat_flag port.
module systolic_array_os
  import systolic_array_os_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = SA_DW,
  parameter int AW   = 24,
  parameter int KW   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*DW-1:0]    a_data,
  input  logic [COLS*DW-1:0]    b_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [((ROWS>1)?$clog2(ROWS):1)-1:0] out_row,
  output logic [COLS*AW-1:0]    out_data,
  output logic                  done
`ifdef SYSTOLIC_SAT_EN
  ,
  output logic                  sat_flag
`endif
);

  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FLUSH_LEN = ROWS + COLS - 1;
  localparam int FW        = $clog2(FLUSH_LEN + 1);

  state_t          r_state, w_state_next;
  logic [KW-1:0]   r_k_len, w_k_len_next;
  logic [KW-1:0]   r_beat_cnt, w_beat_cnt_next;
  logic [FW-1:0]   r_flush_cnt, w_flush_cnt_next;
  logic [RW-1:0]   r_out_row, w_out_row_next;
  logic            w_beat;
  logic            w_clr;

  operand_t             w_a_in [ROWS][COLS];
  operand_t             w_b_in [ROWS][COLS];
  logic signed [AW-1:0] w_acc  [ROWS][COLS];
  logic [ROWS*COLS-1:0] w_sat;

  assign busy      = (r_state != ST_IDLE);
  assign in_ready  = (r_state == ST_LOAD);
  assign out_valid = (r_state == ST_DRAIN);
  assign out_row   = r_out_row;
  assign done      = out_valid & out_ready & (r_out_row == RW'(ROWS - 1));
  assign w_beat    = in_ready & in_valid;
  assign w_clr     = (r_state == ST_IDLE) & start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
      r_out_row   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_k_len     <= w_k_len_next;
      r_beat_cnt  <= w_beat_cnt_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_out_row   <= w_out_row_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_k_len_next     = r_k_len;
    w_beat_cnt_next  = r_beat_cnt;
    w_flush_cnt_next = r_flush_cnt;
    w_out_row_next   = r_out_row;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_k_len_next    = k_len;
          w_beat_cnt_next = '0;
          w_state_next    = (k_len == '0) ? ST_FLUSH : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (r_beat_cnt == r_k_len - KW'(1)) begin
            w_beat_cnt_next = '0;
            w_state_next    = ST_FLUSH;
          end else begin
            w_beat_cnt_next = r_beat_cnt + KW'(1);
          end
        end
      end
      ST_FLUSH: begin
        // Long enough for the last beat to cross the full skewed wavefront.
        if (r_flush_cnt == FW'(FLUSH_LEN - 1)) begin
          w_flush_cnt_next = '0;
          w_out_row_next   = '0;
          w_state_next     = ST_DRAIN;
        end else begin
          w_flush_cnt_next = r_flush_cnt + FW'(1);
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (r_out_row == RW'(ROWS - 1)) begin
            w_out_row_next = '0;
            w_state_next   = ST_IDLE;
          end else begin
            w_out_row_next = r_out_row + RW'(1);
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Row i is delayed i cycles (plus one capture stage) so operands meet at the right PE.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_skew
    operand_t r_sr [gi+1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= gi; s++) r_sr[s] <= '0;
      end else begin
        r_sr[0] <= w_beat ? '{valid: 1'b1, data: a_data[gi*DW +: DW]} : '0;
        for (int s = 1; s <= gi; s++) r_sr[s] <= r_sr[s-1];
      end
    end
    assign w_a_in[gi][0] = r_sr[gi];
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_b_skew
    operand_t r_sr [gi+1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= gi; s++) r_sr[s] <= '0;
      end else begin
        r_sr[0] <= w_beat ? '{valid: 1'b1, data: b_data[gi*DW +: DW]} : '0;
        for (int s = 1; s <= gi; s++) r_sr[s] <= r_sr[s-1];
      end
    end
    assign w_b_in[0][gi] = r_sr[gi];
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      operand_t w_a_o;
      operand_t w_b_o;
      systolic_pe #(.AW(AW)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .i_a   (w_a_in[gi][gj]),
        .i_b   (w_b_in[gi][gj]),
        .o_a   (w_a_o),
        .o_b   (w_b_o),
        .o_acc (w_acc[gi][gj])
`ifdef SYSTOLIC_SAT_EN
        ,
        .o_sat (w_sat[gi*COLS+gj])
`endif
      );
`ifndef SYSTOLIC_SAT_EN
      assign w_sat[gi*COLS+gj] = 1'b0;
`endif
      if (gj < COLS - 1) begin : g_a_fwd
        assign w_a_in[gi][gj+1] = w_a_o;
      end else begin : g_a_end
        operand_t w_unused_a;
        assign w_unused_a = w_a_o;
      end
      if (gi < ROWS - 1) begin : g_b_fwd
        assign w_b_in[gi+1][gj] = w_b_o;
      end else begin : g_b_end
        operand_t w_unused_b;
        assign w_unused_b = w_b_o;
      end
    end
  end

`ifdef SYSTOLIC_SAT_EN
  assign sat_flag = |w_sat;
`else
  logic w_unused_sat;
  assign w_unused_sat = |w_sat;
`endif

  always_comb begin
    out_data = '0;
    if (r_state == ST_DRAIN) begin
      for (int j = 0; j < COLS; j++) out_data[j*AW +: AW] = w_acc[r_out_row][j];
    end
  end

endmodule
